// File: rtl/weight_pingpong_buffer.sv
// Double-banked signed weight buffer: host fills the shadow bank while the active bank streams a burst.
// Optional macro WBUF_TERNARY_EN: output the sign (+1/0/-1) of each stored word instead of the raw word.
module weight_pingpong_buffer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             swap,
  output logic             swap_pending,
  output logic             active_bank,
  input  logic             start,
  input  logic [AW-1:0]    rd_base,
  input  logic [AW:0]      rd_len,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] mem0 [DEPTH];
  logic signed [WIDTH-1:0] mem1 [DEPTH];
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             rd_cnt;
  logic signed [WIDTH-1:0] rd_word_p0;
  logic                    issue;
  logic                    hs;
  logic                    len_ok;

  function automatic logic signed [WIDTH-1:0] fmt_word(input logic signed [WIDTH-1:0] w);
`ifdef WBUF_TERNARY_EN
    if (w == '0)
      return '0;
    else if (w[WIDTH-1])
      return '1;
    else
      return WIDTH'(1);
`else
    return w;
`endif
  endfunction

  // The output register doubles as the prefetch stage: a read is issued only
  // when the word it produces can land in a free (or draining) output slot.
  assign issue      = (state == S_STREAM) && (!out_valid || out_ready);
  assign hs         = out_valid && out_ready;
  assign len_ok     = (rd_len != '0) && (rd_len <= (AW+1)'(DEPTH));
  assign rd_word_p0 = active_bank ? mem1[rd_ptr] : mem0[rd_ptr];

  // Host writes always target the shadow bank; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (active_bank)
        mem0[wr_addr] <= wr_data;
      else
        mem1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      done         <= 1'b0;
      swap_pending <= 1'b0;
      active_bank  <= 1'b0;
      rd_ptr       <= '0;
      rd_cnt       <= '0;
    end else begin
      done <= 1'b0;
      // Stage p0 -> p1: bank read captured into the output register
      if (issue) begin
        out_data  <= fmt_word(rd_word_p0);
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (swap)
            active_bank <= ~active_bank;
          if (start && len_ok) begin
            state  <= S_STREAM;
            busy   <= 1'b1;
            rd_ptr <= rd_base;
            rd_cnt <= rd_len;
          end
        end
        S_STREAM: begin
          if (swap)
            swap_pending <= 1'b1;
          if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt - 1'b1;
            if (rd_cnt == (AW+1)'(1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (swap)
            swap_pending <= 1'b1;
          if (hs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (swap_pending || swap)
              active_bank <= ~active_bank;
            swap_pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Scoreboard bench for weight_pingpong_buffer: stimulus queues expected words, a monitor pops on each handshake.
module tb_weight_pingpong_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             swap = 1'b0;
  logic             swap_pending;
  logic             active_bank;
  logic             start = 1'b0;
  logic [AW-1:0]    rd_base = '0;
  logic [AW:0]      rd_len = '0;
  logic             busy;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             done;

  weight_pingpong_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap(swap), .swap_pending(swap_pending), .active_bank(active_bank),
    .start(start), .rd_base(rd_base), .rd_len(rd_len), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int model [2][DEPTH];
  int bench_bank = 0;
  int hs_cnt = 0;
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] held = '0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_of(input int v);
`ifdef WBUF_TERNARY_EN
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
`else
    return v;
`endif
  endfunction

  // Monitor: pop and compare on every handshake, and check hold during stalls
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall)
        check("stall_hold", int'($signed(out_data)), int'($signed(held)));
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0)
          check("unexpected_word", int'($signed(out_data)), 9999);
        else
          check("word", int'($signed(out_data)), exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      held       = out_data;
    end
  end

  task automatic wr(input int a, input int v);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(v);
    model[1 - bench_bank][a] = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    bench_bank = 1 - bench_bank;
    check("swap_idle_bank", int'(active_bank), bench_bank);
  endtask

  // mode bit0: backpressure pattern; bit1: swap + shadow writes mid-burst; bit2: stray start while busy
  task automatic run_burst(input int base, input int len, input int mode);
    int  cyc;
    int  ndone;
    int  done_cyc;
    bit  fin;
    int  old_bank;
    int  wv [3] = '{-128, -1, 0};
    for (int k = 0; k < len; k++)
      exp_q.push_back(exp_of(model[bench_bank][(base + k) % DEPTH]));
    old_bank  = bench_bank;
    out_ready = 1'b1;
    start     = 1'b1;
    rd_base   = AW'(base);
    rd_len    = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    check("no_valid_yet", int'(out_valid), 0);
    cyc = 0; ndone = 0; done_cyc = -1; fin = 1'b0;
    while (cyc < 300 && !fin) begin
      @(posedge clk); #1;
      out_ready = mode[0] ? pat[cyc % 6][0] : 1'b1;
      if (mode[1]) begin
        swap  = (cyc == 1 || cyc == 2);
        wr_en = 1'b0;
        if (cyc >= 2 && cyc <= 4) begin
          wr_en   = 1'b1;
          wr_addr = AW'(cyc - 2);
          wr_data = WIDTH'(wv[cyc - 2]);
          model[1 - bench_bank][cyc - 2] = wv[cyc - 2];
        end
      end
      if (mode[2]) begin
        start   = (cyc == 3);
        rd_base = AW'(base + 5);
      end
      @(negedge clk);
      if (cyc == 0)
        check("first_valid", int'(out_valid), 1);
      if (mode[1] && cyc == 4) begin
        check("swap_pending_set", int'(swap_pending), 1);
        check("bank_held_busy", int'(active_bank), old_bank);
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      cyc++;
    end
    out_ready = 1'b1;
    check("done_count", ndone, 1);
    check("busy_in_done", int'(busy), 0);
    if (mode[0] == 1'b0)
      check("done_latency", done_cyc, len);
    if (mode[1]) begin
      bench_bank = 1 - bench_bank;
      check("swap_pending_clr", int'(swap_pending), 0);
      check("bank_toggled", int'(active_bank), bench_bank);
    end
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("done_single", int'(done), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_pending", int'(swap_pending), 0);
    check("rst_bank", int'(active_bank), 0);
    check("rst_data", int'(out_data), 0);

    // Bank1 via shadow: filler plus 55 @3 and 127 @7, then swap and burst 3..7
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1);
    wr(3, 55);
    wr(7, 127);
    do_swap();
    run_burst(3, 5, 0);

    // Bank0 filled while bank1 active, then wrap burst 14,15,0,1
    for (int i = 0; i < DEPTH; i++) wr(i, i * 7 - 50);
    do_swap();
    run_burst(14, 4, 0);

    // rd_len == 0 is ignored
    start = 1'b1; rd_base = '0; rd_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_len_ignored", int'(busy), 0);

    // Backpressure plus a stray start while busy
    run_burst(0, 8, 3'b101);

    // Swap while busy with shadow writes of -128, -1, 0 into bank1
    run_burst(8, 8, 3'b011);
    run_burst(0, 4, 0);

    // Reset after two of six words
    for (int k = 0; k < 6; k++) exp_q.push_back(exp_of(model[bench_bank][k]));
    out_ready = 1'b1;
    hs_cnt  = 0;
    start   = 1'b1; rd_base = '0; rd_len = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_words", hs_cnt, 2);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_bank", int'(active_bank), 0);
    exp_q.delete();
    bench_bank = 0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", int'(done), 0);
      @(negedge clk);
    end
    run_burst(0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
